// File: rtl/npc_gen_32.sv
// Next-PC generator: selects sequential/branch/jump/jr target for the PC register
// and owns the fetch-control FSM (run, stall, halt, one-cycle fault redirect).
module npc_gen_32 #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
    input  logic [31:0] rs_val,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        jr,
    input  logic        stall,
    input  logic        halt,
    output logic [31:0] next_addr,
    output logic [31:0] pc_plus4,
    output logic [1:0]  state,
    output logic        fault,
    output logic [31:0] epc,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_STALL  = 2'd1,
        S_HALTED = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t      cur_state;
    state_t      nxt_state;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        taken;
    logic        misaligned;
    logic        hold;
    logic        retire;

    assign pc_plus4   = pc + 32'd4;
    assign br_offset  = {{14{imm16[15]}}, imm16, 2'b00};
    assign br_target  = pc_plus4 + br_offset;
    assign j_target   = {pc_plus4[31:28], jtarget, 2'b00};
    assign taken      = branch & zero;
    assign misaligned = jr & (rs_val[1:0] != 2'b00);
    assign hold       = halt | stall;
    // Halt and stall both outrank a misaligned jr, so a stalled jr is only judged once stall drops.
    assign retire     = (cur_state == S_RUN) & ~hold & ~misaligned;

    // Target select; reset overrides everything so the PC register loads the vector.
    always_comb begin
        // NOTE: default assigned first so every path drives next_addr and no latch is inferred.
        next_addr = pc;
        if (reset) begin
            next_addr = RESET_VECTOR;
        end else if (cur_state == S_RUN && !hold) begin
            if (misaligned)  next_addr = EXC_VECTOR;
            else if (jr)     next_addr = rs_val;
            else if (jump)   next_addr = j_target;
            else if (taken)  next_addr = br_target;
            else             next_addr = pc_plus4;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        unique case (cur_state)
            S_RUN: begin
                if (halt)            nxt_state = S_HALTED;
                else if (stall)      nxt_state = S_STALL;
                else if (misaligned) nxt_state = S_FAULT;
                else                 nxt_state = S_RUN;
            end
            S_STALL: begin
                if (halt)       nxt_state = S_HALTED;
                else if (stall) nxt_state = S_STALL;
                else            nxt_state = S_RUN;
            end
            S_HALTED: nxt_state = S_HALTED;
            S_FAULT:  nxt_state = halt ? S_HALTED : S_RUN;
            default:  nxt_state = S_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_RUN;
            epc       <= 32'd0;
            retired   <= 32'd0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_RUN && nxt_state == S_FAULT) epc <= pc;
            if (retire) retired <= retired + 32'd1;
        end
    end

    assign state = cur_state;
    assign fault = (cur_state == S_FAULT);

endmodule

// File: tb/tb_npc_gen_32.sv
// Self-checking bench for npc_gen_32: vector table, directed FSM sequences,
// and randomized stimulus against a behavioural model.
module tb_npc_gen_32;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] EV = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [31:0] rs_val;
    logic        branch, zero, jump, jr, stall, halt;
    logic [31:0] next_addr, pc_plus4, epc, retired;
    logic [1:0]  state;
    logic        fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    npc_gen_32 #(.RESET_VECTOR(RV), .EXC_VECTOR(EV)) dut (
        .clk(clk), .reset(reset), .pc(pc), .imm16(imm16), .jtarget(jtarget),
        .rs_val(rs_val), .branch(branch), .zero(zero), .jump(jump), .jr(jr),
        .stall(stall), .halt(halt), .next_addr(next_addr), .pc_plus4(pc_plus4),
        .state(state), .fault(fault), .epc(epc), .retired(retired)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_ctl();
        branch = 0; zero = 0; jump = 0; jr = 0; stall = 0; halt = 0;
        imm16 = '0; jtarget = '0; rs_val = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [15:0] imm16;
        logic [25:0] jtarget;
        logic [31:0] rs_val;
        logic        branch, zero, jump, jr;
        logic [31:0] exp_next;
        logic [31:0] exp_plus4;
    } vec_t;

    // Behavioural reference model state
    int          m_state;
    logic [31:0] m_epc, m_ret;

    function automatic logic [31:0] model_next();
        logic [31:0] p4;
        int          s;
        p4 = pc + 32'd4;
        s  = int'($signed(imm16));
        if (reset)                          return RV;
        if (m_state != 0 || halt || stall)  return pc;
        if (jr && (rs_val % 4) != 0)        return EV;
        if (jr)                             return rs_val;
        if (jump)                           return (p4 & 32'hF000_0000) | (32'(jtarget) << 2);
        if (branch && zero)                 return p4 + 32'(s * 4);
        return p4;
    endfunction

    task automatic model_update();
        logic mis;
        mis = jr && (rs_val % 4) != 0;
        if (reset) begin
            m_state = 0; m_epc = 0; m_ret = 0;
        end else begin
            case (m_state)
                0: if (halt) m_state = 2;
                   else if (stall) m_state = 1;
                   else if (mis) begin m_state = 3; m_epc = pc; end
                   else m_ret = m_ret + 1;
                1: m_state = halt ? 2 : (stall ? 1 : 0);
                2: m_state = 2;
                default: m_state = halt ? 2 : 0;
            endcase
        end
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'h0000_0010, 16'hFFFE, 26'h0, 32'h0, 1, 1, 0, 0, 32'h0000_000C, 32'h0000_0014};
        vecs[1] = '{32'h0000_0010, 16'hFFFE, 26'h0, 32'h0, 1, 0, 0, 0, 32'h0000_0014, 32'h0000_0014};
        vecs[2] = '{32'h1000_0000, 16'h0, 26'h000_0100, 32'h0, 1, 1, 1, 0, 32'h1000_0400, 32'h1000_0004};
        vecs[3] = '{32'h1000_0000, 16'h0, 26'h000_0100, 32'h0000_2000, 1, 1, 1, 1, 32'h0000_2000, 32'h1000_0004};
        vecs[4] = '{32'hFFFF_FFFC, 16'h0, 26'h0, 32'h0, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{32'h0000_0020, 16'h0, 26'h0, 32'h0000_0102, 0, 0, 0, 1, 32'h0000_0080, 32'h0000_0024};
        vecs[6] = '{32'hF000_0000, 16'h0, 26'h3FF_FFFF, 32'h0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'hF000_0004};
        vecs[7] = '{32'h7FFF_FFF0, 16'h7FFF, 26'h0, 32'h0, 1, 1, 0, 0, 32'h8001_FFF0, 32'h7FFF_FFF4};
        vecs[8] = '{32'h0000_002C, 16'h0, 26'h0, 32'h0000_1001, 1, 1, 1, 1, 32'h0000_0080, 32'h0000_0030};
        vecs[9] = '{32'h0000_002C, 16'h0, 26'h0, 32'h0, 1, 1, 0, 0, 32'h0000_0030, 32'h0000_0030};

        clear_ctl();
        reset = 1; pc = 32'h0000_0040;

        // Reset and sequential fetch
        step();
        check("rst_next", next_addr, RV);
        check("rst_state", 32'(state), 0);
        check("rst_retired", retired, 0);
        check("rst_epc", epc, 0);
        check("rst_fault", 32'(fault), 0);
        reset = 0; pc = 0;
        #1;
        check("seq_next", next_addr, 32'h4);
        step(); step(); step();
        check("retired_3", retired, 3);

        // Vector table, controls cleared before each edge so the FSM stays in RUN
        for (int i = 0; i < 10; i++) begin
            step();
            pc = vecs[i].pc; imm16 = vecs[i].imm16; jtarget = vecs[i].jtarget;
            rs_val = vecs[i].rs_val; branch = vecs[i].branch; zero = vecs[i].zero;
            jump = vecs[i].jump; jr = vecs[i].jr;
            #1;
            check($sformatf("vec%0d_next", i), next_addr, vecs[i].exp_next);
            check($sformatf("vec%0d_plus4", i), pc_plus4, vecs[i].exp_plus4);
            clear_ctl();
        end

        // Fault redirect
        reset = 1; step();
        reset = 0; pc = 32'h20; jr = 1; rs_val = 32'h0000_0102;
        #1;
        check("flt_next", next_addr, EV);
        step();
        check("flt_state", 32'(state), 3);
        check("flt_fault", 32'(fault), 1);
        check("flt_epc", epc, 32'h20);
        check("flt_retired", retired, 0);
        check("flt_hold", next_addr, 32'h20);
        clear_ctl(); stall = 1;
        step();
        check("flt_exit", 32'(state), 0);
        check("flt_retired2", retired, 0);
        stall = 0;
        step();
        check("run_retired", retired, 1);
        check("epc_kept", epc, 32'h20);

        // Stall then halt
        pc = 32'h8; stall = 1;
        #1;
        check("stl_next", next_addr, 32'h8);
        step();
        check("stl_state", 32'(state), 1);
        check("stl_next2", next_addr, 32'h8);
        step();
        check("stl_state2", 32'(state), 1);
        check("stl_retired", retired, 1);
        halt = 1;
        step();
        check("hlt_state", 32'(state), 2);
        halt = 0; stall = 0;
        step();
        check("hlt_stays", 32'(state), 2);
        check("hlt_next", next_addr, 32'h8);
        pc = 32'h100;
        #1;
        check("hlt_next2", next_addr, 32'h100);
        check("hlt_retired", retired, 1);
        reset = 1;
        #1;
        check("rst_comb", next_addr, RV);
        step();
        check("rst_exit", 32'(state), 0);
        check("rst_retired2", retired, 0);

        // Randomized against the model
        m_state = 0; m_epc = 0; m_ret = 0;
        for (int n = 0; n < 3000; n++) begin
            reset   = ($urandom_range(39) == 0);
            halt    = ($urandom_range(49) == 0);
            stall   = ($urandom_range(4) == 0);
            jr      = ($urandom_range(3) == 0);
            jump    = ($urandom_range(3) == 0);
            branch  = ($urandom_range(2) == 0);
            zero    = $urandom_range(1) != 0;
            pc      = $urandom;
            imm16   = 16'($urandom);
            jtarget = 26'($urandom);
            rs_val  = $urandom;
            if ($urandom_range(1) == 0) rs_val[1:0] = 2'b00;
            #1;
            check("rnd_next", next_addr, model_next());
            check("rnd_plus4", pc_plus4, pc + 32'd4);
            check("rnd_state", 32'(state), 32'(m_state));
            check("rnd_fault", 32'(fault), (m_state == 3) ? 32'd1 : 32'd0);
            check("rnd_epc", epc, m_epc);
            check("rnd_retired", retired, m_ret);
            model_update();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/npc_gen_32.md
Name: npc_gen_32

Overview:
- Next-PC generator directly upstream of the PC register.
- Takes the current PC (the PC register's new_addr) plus decode/ALU results, selects sequential/branch/jump/jump-register target, drives the PC register's addr input.
- Owns fetch-control FSM: run, stall, halt, one-cycle fault redirect. Keeps EPC and a retired-instruction counter.

Parameters:
- RESET_VECTOR, 32'h0000_0000, next_addr value presented while reset is high.
- EXC_VECTOR, 32'h0000_0080, redirect target on misaligned jr.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pc  in  32  current PC, from PC register output
- imm16  in  16  branch offset in words, signed
- jtarget  in  26  J-type target field
- rs_val  in  32  register rs value for jr
- branch  in  1  instruction is conditional branch
- zero  in  1  ALU zero flag; branch taken = branch & zero
- jump  in  1  instruction is j/jal
- jr  in  1  instruction is jr
- stall  in  1  hold PC this cycle
- halt  in  1  stop fetching until reset
- next_addr  out  32  combinational next PC, to PC register addr input
- pc_plus4  out  32  pc + 4, combinational (jal link value)
- state  out  2  FSM state: 0 RUN, 1 STALL, 2 HALTED, 3 FAULT
- fault  out  1  high during FAULT state
- epc  out  32  PC of last faulting jr
- retired  out  32  count of instructions completed in RUN

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset (sampled at posedge): state=RUN, epc=0, retired=0, fault=0. While reset is high, next_addr=RESET_VECTOR regardless of state/inputs. Reset mid-stall/halt/fault returns to RUN, same values.
- Arithmetic, mod 2^32, no carry out:
  - pc_plus4 = pc + 4
  - branch target = pc_plus4 + ({{14{imm16[15]}}, imm16, 2'b00})
  - jump target = {pc_plus4[31:28], jtarget, 2'b00}
  - jr target = rs_val
- Target priority in RUN: jr > jump > branch taken > pc_plus4.
- Misaligned = jr & (rs_val[1:0] != 0). jump/branch targets are always aligned by construction.
- next_addr per state (reset low):
  - RUN, halt or stall asserted: pc (hold).
  - RUN, misaligned: EXC_VECTOR.
  - RUN, otherwise: selected target.
  - STALL, HALTED, FAULT: pc (hold).
- Transitions (evaluated at posedge, reset low):
  - RUN: halt -> HALTED; else stall -> STALL; else misaligned -> FAULT (epc <= pc); else RUN.
  - STALL: halt -> HALTED; else stall -> STALL; else RUN.
  - HALTED: stays HALTED; only reset exits.
  - FAULT: exactly one cycle; halt -> HALTED; else RUN. stall is ignored in FAULT.
- Simultaneous events: halt dominates stall dominates misaligned jr. A jr with stall high does not fault; it is re-evaluated when stall drops.
- retired increments by 1 at posedge only when state=RUN and none of halt, stall, misaligned are true. Wraps 32'hFFFF_FFFF -> 0. Never increments in STALL/HALTED/FAULT.
- fault = (state==FAULT). epc holds its value until the next fault or reset.
- Latency: next_addr is combinational from pc/inputs, so the PC register loads it at the same edge that updates this FSM. A redirect takes effect on the next cycle's pc.

Test Plan:
- Reset: reset=1 with pc=32'h0000_0040 -> next_addr=32'h0000_0000, state=0, retired=0. Release reset, pc=0, no control -> next_addr=32'h0000_0004; after 3 edges retired=3.
- Branch: pc=32'h0000_0010, branch=1, zero=1, imm16=16'hFFFE -> next_addr=32'h0000_000C. Same with zero=0 -> 32'h0000_0014.
- Jump/priority: pc=32'h1000_0000, jump=1, jtarget=26'h000_0100, branch=zero=1 -> next_addr=32'h1000_0400. Add jr=1, rs_val=32'h0000_2000 -> next_addr=32'h0000_2000.
- Fault: pc=32'h0000_0020, jr=1, rs_val=32'h0000_0102 -> next_addr=32'h0000_0080. After edge: state=3, fault=1, epc=32'h0000_0020, retired unchanged. Next edge: state=0.
- Stall/halt: stall=1 for 2 cycles at pc=32'h0000_0008 -> next_addr=32'h0000_0008, retired frozen, state=1. Then halt=1 with stall=1 -> state=2. Drop both -> stays 2 with next_addr=pc. Assert reset -> state=0, next_addr=RESET_VECTOR.
- Wrap: force retired near wrap by running 2^32 cycles (or a bench shortcut), or check pc=32'hFFFF_FFFC with no control -> next_addr=32'h0000_0000, pc_plus4=0.
